imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
Shares one single-ported synchronous 32-bit word memory between the core's instruction-fetch port (I) and its load/store port (D). Each cycle it grants at most one requester, drives the memory port, and routes the read data back one cycle later with a valid strobe. Data accesses have priority. A saturating wait counter guarantees fetch forward progress. Sits between the core and the unified program/data memory.

Parameters:
AW, 9, memory word-address width (512 words)
MAX_WAIT, 3, consecutive denied fetch cycles after which fetch wins over data (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
i_req  input  1  fetch request; held until i_gnt
i_addr  input  32  fetch byte address
i_gnt  output  1  fetch accepted this cycle (combinational)
i_rvalid  output  1  fetch data valid (registered)
i_rdata  output  32  fetch data; 0 when i_rvalid low
d_req  input  1  data request; held until d_gnt
d_we  input  1  1 = write, 0 = read
d_addr  input  32  data byte address
d_wdata  input  32  write data
d_gnt  output  1  data accepted this cycle (combinational)
d_rvalid  output  1  data response/ack valid (registered)
d_rdata  output  32  read data; 0 on write acks and when d_rvalid low
mem_en  output  1  memory access this cycle
mem_we  output  1  memory write enable
mem_addr  output  AW  word address = granted addr[AW+1:2]
mem_wd  output  32  memory write data
mem_rd  input  32  memory read data, valid cycle after mem_en

Behaviour:
- Clock clk; reset synchronous, active-high.
- Reset: wait_cnt=0, inflight=OWN_NONE, i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0. While reset is high, i_gnt=0, d_gnt=0, mem_en=0, mem_we=0.
- Grant, combinational from the current-cycle inputs and wait_cnt:
  - only i_req -> I
  - only d_req -> D
  - both -> D, unless wait_cnt==MAX_WAIT, then I
  - neither -> none, mem_en=0
- Granted cycle: mem_en=1, mem_addr from the granted address, mem_we=d_we&d_gnt, mem_wd=d_wdata. With no grant, mem_addr/mem_wd are driven 0.
- Address rules: byte-address bits [1:0] are ignored (word aligned). Bits above AW+1 are ignored, so addresses wrap modulo 2^AW words.
- inflight register, next value: OWN_I if I granted, OWN_D_RD if D read granted, OWN_D_WR if D write granted, else OWN_NONE.
- Response, one cycle after grant:
  - inflight==OWN_I: i_rvalid=1, i_rdata=mem_rd
  - OWN_D_RD: d_rvalid=1, d_rdata=mem_rd
  - OWN_D_WR: d_rvalid=1, d_rdata=0
- Pipelining: a new grant may issue in the same cycle as the previous grant's response. Back-to-back throughput is 1 access/cycle.
- wait_cnt, 0..MAX_WAIT:
  - cleared when i_gnt=1 or i_req=0
  - otherwise incremented, saturating at MAX_WAIT
- Starvation bound: under continuous d_req, fetch waits at most MAX_WAIT cycles.
- Requesters must hold req/addr/we/wdata stable until granted; the arbiter does not latch ungranted requests.
- Reset during an access: the in-flight response is discarded and no rvalid appears after reset deasserts. A req still held after reset deasserts is re-arbitrated normally.
- Simultaneous grant and response on the same port (back-to-back reads) are legal and independent.

Decomposition:
- Package mem_arb_pkg:
  - enum owner_e {OWN_NONE, OWN_I, OWN_D_RD, OWN_D_WR}
  - WORD_BYTES=4
  - localparam DATA_W=32
- Sub-module sat_counter (parameter MAX; ports clk, reset, inc, clr, count, at_max) for wait_cnt.
- Everything else stays in imem_dmem_arbiter.
- Bench memory model: synchronous 2^AW-word RAM, 1-cycle read latency.

Test Plan:
1. Memory word0=32'hE3A09000; i_req=1, i_addr=0x0, d_req=0 -> i_gnt=1 same cycle, mem_addr=0; next cycle i_rvalid=1, i_rdata=32'hE3A09000, d_rvalid=0.
2. i_req and d_req (read, d_addr=0x4, word1=32'hE3A00008) both high in one cycle -> d_gnt=1, i_gnt=0; next cycle d_rvalid=1, d_rdata=32'hE3A00008; i granted the following cycle.
3. d_req held high continuously, i_req high, MAX_WAIT=3 -> i_gnt=0 for 3 cycles, i_gnt=1 on the 4th; wait_cnt returns to 0; d_gnt resumes the next cycle.
4. d_we=1, d_addr=0xFC, d_wdata=0x0000002A, then fetch read of 0xFC -> mem_we=1 at mem_addr=63; write ack d_rvalid=1 with d_rdata=0; fetch later returns i_rdata=0x0000002A.
5. i_addr=0x803 with AW=9 -> mem_addr=0 (wrap plus low bits ignored), i_rdata=word0.
6. I granted, reset asserted next cycle for 2 cycles -> no i_rvalid during or after reset; wait_cnt=0; the first post-reset request is serviced with 1-cycle latency.

Source files
------------

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// The owner tag records which requester the memory read data belongs to
// in the cycle after a grant.
package mem_arb_pkg;

    localparam int DATA_W     = 32;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D_RD = 2'd2,
        OWN_D_WR = 2'd3
    } owner_e;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the memory port.
// The slave view is the arbiter itself; the master view is whatever sits
// around it (the core on one side and the memory on the other).
interface imem_dmem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = 9
);

    logic              i_req;
    logic [DATA_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [DATA_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wd
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wd
    );

endinterface

// File: rtl/imem_dmem_arbiter_sat_counter.sv
// Saturating up-counter with a synchronous clear. Clear beats increment,
// and the count sticks at MAX until cleared.
module sat_counter #(
    parameter int MAX = 3,
    localparam int CW = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          at_max
);

    assign at_max = (count == CW'(MAX));

    // Count up while asked to, stop at MAX, drop to zero on clear or reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-ported synchronous word memory between the
// instruction-fetch port and the load/store port. Data wins by default;
// a fetch that has been refused MAX_WAIT cycles in a row wins next.
// Read data comes back one cycle after the grant, steered by an owner tag.
module imem_dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 9,
    parameter int MAX_WAIT = 3
) (
    input logic                 clk,
    input logic                 reset,
    imem_dmem_arbiter_if.slave  bus
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic          grant_i;
    logic          grant_d;
    logic [CW-1:0] wait_cnt;
    logic          wait_max;
    owner_e        inflight;
    owner_e        inflight_nxt;

    // Address bits the word memory never sees: byte offset and wrap bits.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.i_addr[DATA_W-1:AW+2], bus.i_addr[1:0],
                                bus.d_addr[DATA_W-1:AW+2], bus.d_addr[1:0]};

    sat_counter #(
        .MAX (MAX_WAIT)
    ) u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (bus.i_req && !grant_i),
        .clr    (grant_i || !bus.i_req),
        .count  (wait_cnt),
        .at_max (wait_max)
    );

    // Pick the winner for this cycle and drive the memory port from it.
    always_comb begin
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        bus.mem_en   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_wd   = '0;
        inflight_nxt = OWN_NONE;
        if (!reset) begin
            grant_i = bus.i_req && (!bus.d_req || wait_max);
            grant_d = bus.d_req && !grant_i;
        end
        if (grant_i) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.i_addr[AW+1:2];
            bus.mem_wd   = bus.d_wdata;
            inflight_nxt = OWN_I;
        end else if (grant_d) begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = bus.d_we;
            bus.mem_addr = bus.d_addr[AW+1:2];
            bus.mem_wd   = bus.d_wdata;
            inflight_nxt = bus.d_we ? OWN_D_WR : OWN_D_RD;
        end
    end

    assign bus.i_gnt = grant_i;
    assign bus.d_gnt = grant_d;

    // Remember who owns the memory read data arriving next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= OWN_NONE;
        end else begin
            inflight <= inflight_nxt;
        end
    end

    // Steer the response; a reset cycle suppresses any response still in flight.
    always_comb begin
        bus.i_rvalid = 1'b0;
        bus.i_rdata  = '0;
        bus.d_rvalid = 1'b0;
        bus.d_rdata  = '0;
        if (!reset) begin
            case (inflight)
                OWN_I: begin
                    bus.i_rvalid = 1'b1;
                    bus.i_rdata  = bus.mem_rd;
                end
                OWN_D_RD: begin
                    bus.d_rvalid = 1'b1;
                    bus.d_rdata  = bus.mem_rd;
                end
                OWN_D_WR: begin
                    bus.d_rvalid = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: a table of one-cycle vectors for
// the basic grant/response behaviour, then hand-written sequences for
// fetch starvation and reset in the middle of an access.
module tb_imem_dmem_arbiter;

    localparam int AW       = 9;
    localparam int MAX_WAIT = 3;

    localparam logic [31:0] W0   = 32'hE3A09000;
    localparam logic [31:0] W1   = 32'hE3A00008;
    localparam logic [31:0] W511 = 32'hA5A50001;

    typedef struct {
        logic        rst;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_igt;
        logic        e_dgt;
        logic        e_en;
        logic        e_we;
        logic [8:0]  e_addr;
        logic [31:0] e_wd;
        logic        e_iv;
        logic [31:0] e_id;
        logic        e_dv;
        logic [31:0] e_dd;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    imem_dmem_arbiter_if #(.AW(AW)) bus ();

    imem_dmem_arbiter #(
        .AW       (AW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous RAM, one cycle read latency.
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] mem_rd_q = 32'h0;
    assign bus.mem_rd = mem_rd_q;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wd;
            else            mem_rd_q <= mem[bus.mem_addr];
        end
    end

    function automatic vec_t mkv(
        input logic rst, input logic ir, input logic [31:0] ia,
        input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
        input logic eig, input logic edg, input logic een, input logic ewe,
        input logic [8:0] ema, input logic [31:0] ewd,
        input logic eiv, input logic [31:0] eid, input logic edv, input logic [31:0] edd);
        vec_t v;
        v.rst = rst; v.i_req = ir; v.i_addr = ia;
        v.d_req = dr; v.d_we = dwe; v.d_addr = da; v.d_wdata = dwd;
        v.e_igt = eig; v.e_dgt = edg; v.e_en = een; v.e_we = ewe;
        v.e_addr = ema; v.e_wd = ewd;
        v.e_iv = eiv; v.e_id = eid; v.e_dv = edv; v.e_dd = edd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle: drive just after the rising edge, leave time to settle.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        reset       = v.rst;
        bus.i_req   = v.i_req;
        bus.i_addr  = v.i_addr;
        bus.d_req   = v.d_req;
        bus.d_we    = v.d_we;
        bus.d_addr  = v.d_addr;
        bus.d_wdata = v.d_wdata;
        #3;
    endtask

    task automatic checkOutput(input vec_t v, input string lbl);
        chk({lbl, ".i_gnt"},    32'(bus.i_gnt),    32'(v.e_igt));
        chk({lbl, ".d_gnt"},    32'(bus.d_gnt),    32'(v.e_dgt));
        chk({lbl, ".mem_en"},   32'(bus.mem_en),   32'(v.e_en));
        chk({lbl, ".mem_we"},   32'(bus.mem_we),   32'(v.e_we));
        chk({lbl, ".mem_addr"}, 32'(bus.mem_addr), 32'(v.e_addr));
        chk({lbl, ".mem_wd"},   bus.mem_wd,        v.e_wd);
        chk({lbl, ".i_rvalid"}, 32'(bus.i_rvalid), 32'(v.e_iv));
        chk({lbl, ".i_rdata"},  bus.i_rdata,       v.e_id);
        chk({lbl, ".d_rvalid"}, 32'(bus.d_rvalid), 32'(v.e_dv));
        chk({lbl, ".d_rdata"},  bus.d_rdata,       v.e_dd);
    endtask

    task automatic step(input vec_t v, input string lbl);
        applyStimulus(v);
        checkOutput(v, lbl);
    endtask

    vec_t tbl [13];

    initial begin
        checks   = 0;
        failures = 0;
        reset       = 1'b1;
        bus.i_req   = 1'b0;
        bus.i_addr  = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        for (int k = 0; k < (1 << AW); k++) mem[k] = 32'h0;
        mem[0]   = W0;
        mem[1]   = W1;
        mem[511] = W511;

        //              rst ir ia        dr dwe da          dwd          ig dg en we addr  wd           iv id     dv dd
        tbl[0]  = mkv(1, 1, 32'h0,    1, 0, 32'h4,    32'h0,       0, 0, 0, 0, 9'd0,  32'h0,       0, 32'h0, 0, 32'h0);
        tbl[1]  = mkv(1, 1, 32'h0,    1, 0, 32'h4,    32'h0,       0, 0, 0, 0, 9'd0,  32'h0,       0, 32'h0, 0, 32'h0);
        tbl[2]  = mkv(0, 0, 32'h0,    0, 0, 32'h0,    32'h0,       0, 0, 0, 0, 9'd0,  32'h0,       0, 32'h0, 0, 32'h0);
        tbl[3]  = mkv(0, 1, 32'h0,    0, 0, 32'h0,    32'h0,       1, 0, 1, 0, 9'd0,  32'h0,       0, 32'h0, 0, 32'h0);
        tbl[4]  = mkv(0, 1, 32'h0,    1, 0, 32'h4,    32'h0,       0, 1, 1, 0, 9'd1,  32'h0,       1, W0,    0, 32'h0);
        tbl[5]  = mkv(0, 1, 32'h0,    0, 0, 32'h0,    32'h0,       1, 0, 1, 0, 9'd0,  32'h0,       0, 32'h0, 1, W1);
        tbl[6]  = mkv(0, 0, 32'h0,    1, 1, 32'hFC,   32'h2A,      0, 1, 1, 1, 9'd63, 32'h2A,      1, W0,    0, 32'h0);
        tbl[7]  = mkv(0, 1, 32'hFC,   0, 0, 32'h0,    32'h0,       1, 0, 1, 0, 9'd63, 32'h0,       0, 32'h0, 1, 32'h0);
        tbl[8]  = mkv(0, 1, 32'h803,  0, 0, 32'h0,    32'h0,       1, 0, 1, 0, 9'd0,  32'h0,       1, 32'h2A, 0, 32'h0);
        tbl[9]  = mkv(0, 0, 32'h0,    1, 0, 32'hFE,   32'h0,       0, 1, 1, 0, 9'd63, 32'h0,       1, W0,    0, 32'h0);
        tbl[10] = mkv(0, 0, 32'h0,    1, 0, 32'h7FC,  32'h0,       0, 1, 1, 0, 9'd511,32'h0,       0, 32'h0, 1, 32'h2A);
        tbl[11] = mkv(0, 0, 32'h0,    0, 0, 32'h0,    32'h0,       0, 0, 0, 0, 9'd0,  32'h0,       0, 32'h0, 1, W511);
        tbl[12] = mkv(0, 0, 32'h0,    0, 0, 32'h0,    32'h0,       0, 0, 0, 0, 9'd0,  32'h0,       0, 32'h0, 0, 32'h0);

        for (int r = 0; r < 13; r++) step(tbl[r], $sformatf("tbl%0d", r));

        // Fetch starvation: data held continuously, fetch wins on the 4th cycle.
        for (int s = 0; s < MAX_WAIT; s++)
            step(mkv(0, 1, 32'h0, 1, 0, 32'h4, 32'h0, 0, 1, 1, 0, 9'd1, 32'h0,
                     0, 32'h0, (s > 0), (s > 0) ? W1 : 32'h0), $sformatf("starve%0d", s));
        step(mkv(0, 1, 32'h0, 1, 0, 32'h4, 32'h0, 1, 0, 1, 0, 9'd0, 32'h0, 0, 32'h0, 1, W1), "starve_win");
        step(mkv(0, 1, 32'h0, 1, 0, 32'h4, 32'h0, 0, 1, 1, 0, 9'd1, 32'h0, 1, W0, 0, 32'h0), "starve_resume");
        step(mkv(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 9'd0, 32'h0, 0, 32'h0, 1, W1), "starve_drain");

        // Reset right after a fetch grant: the pending response is dropped.
        step(mkv(0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 0, 9'd0, 32'h0, 0, 32'h0, 0, 32'h0), "rst_grant");
        step(mkv(1, 1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 9'd0, 32'h0, 0, 32'h0, 0, 32'h0), "rst_hold0");
        step(mkv(1, 1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 9'd0, 32'h0, 0, 32'h0, 0, 32'h0), "rst_hold1");
        step(mkv(0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 0, 9'd0, 32'h0, 0, 32'h0, 0, 32'h0), "rst_regrant");
        step(mkv(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 9'd0, 32'h0, 1, W0,    0, 32'h0), "rst_resp");

        // Reset clears a partly built wait count: full MAX_WAIT denials again.
        step(mkv(0, 1, 32'h0, 1, 0, 32'h4, 32'h0, 0, 1, 1, 0, 9'd1, 32'h0, 0, 32'h0, 0, 32'h0), "wrst_a");
        step(mkv(0, 1, 32'h0, 1, 0, 32'h4, 32'h0, 0, 1, 1, 0, 9'd1, 32'h0, 0, 32'h0, 1, W1),    "wrst_b");
        step(mkv(1, 1, 32'h0, 1, 0, 32'h4, 32'h0, 0, 0, 0, 0, 9'd0, 32'h0, 0, 32'h0, 0, 32'h0), "wrst_rst");
        for (int s = 0; s < MAX_WAIT; s++)
            step(mkv(0, 1, 32'h0, 1, 0, 32'h4, 32'h0, 0, 1, 1, 0, 9'd1, 32'h0,
                     0, 32'h0, (s > 0), (s > 0) ? W1 : 32'h0), $sformatf("wrst_deny%0d", s));
        step(mkv(0, 1, 32'h0, 1, 0, 32'h4, 32'h0, 1, 0, 1, 0, 9'd0, 32'h0, 0, 32'h0, 1, W1), "wrst_win");
        step(mkv(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 9'd0, 32'h0, 1, W0,    0, 32'h0), "wrst_resp");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
